// File: rtl/sd_spi_master_if.sv
// CPU register bus for the SD SPI master: one word-addressed port with byte
// write enables and a combinational read-data return.
interface sd_spi_master_if;
  logic        select;
  logic [1:0]  addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output select,
    output addr,
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  select,
    input  addr,
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/sd_spi_master.sv
// SPI mode-0 master for the SD card: one byte per transfer, MSB first,
// software-controlled chip select, level transfer-complete interrupt.
// Optional feature: define SD_SPI_CRC7_EN to add a CRC7 register at addr 2
// that accumulates every transmitted bit (poly x^7+x^3+1).
module sd_spi_master #(
  parameter int unsigned DEFAULT_DIV = 62,
  parameter int unsigned DIV_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  sd_spi_master_if.slave  bus,
  output logic            xfer_done,
  output logic            sd_sclk,
  output logic            sd_mosi,
  input  logic            sd_miso,
  output logic            sd_cs_n
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StFin} state_e;

  localparam logic [DIV_W-1:0] CntOne = DIV_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_lat_q, div_lat_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_q, rx_d;
  logic             cs_q, cs_d;
  logic             done_q, done_d;

  logic wr_data, wr_ctrl, busy, tx_bit, sample;

  assign wr_data   = bus.select && bus.we[0] && (bus.addr == 2'd0);
  assign wr_ctrl   = bus.select && (bus.addr == 2'd1);
  assign busy      = (state_q != StIdle);
  assign tx_bit    = tx_q[3'd7 - bit_q];
  // First HI cycle: the card's bit has been stable for the whole LO phase.
  assign sample    = (state_q == StHi) && (cnt_q == '0);
  assign xfer_done = done_q;
  assign sd_cs_n   = ~cs_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      div_lat_q <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      sh_q      <= '0;
      rx_q      <= '0;
      cs_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      div_lat_q <= div_lat_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      sh_q      <= sh_d;
      rx_q      <= rx_d;
      cs_q      <= cs_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic, register writes and SPI pin drive.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    div_lat_d = div_lat_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    sh_d      = sh_q;
    rx_d      = rx_q;
    cs_d      = cs_q;
    done_d    = done_q;
    sd_sclk   = 1'b0;
    sd_mosi   = 1'b1;

    if (wr_ctrl && bus.we[0]) begin
      cs_d = bus.wdata[0];
      if (bus.wdata[2]) done_d = 1'b0;
    end
    if (wr_ctrl && bus.we[1]) div_d = bus.wdata[8 +: DIV_W];

    unique case (state_q)
      StIdle: begin
        if (wr_data) begin
          tx_d      = bus.wdata[7:0];
          div_lat_d = div_q;
          cnt_d     = '0;
          bit_d     = '0;
          done_d    = 1'b0;
          state_d   = StLo;
        end
      end
      StLo: begin
        sd_mosi = tx_bit;
        if (cnt_q == div_lat_q) begin
          cnt_d   = '0;
          state_d = StHi;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHi: begin
        sd_sclk = 1'b1;
        sd_mosi = tx_bit;
        if (sample) sh_d = {sh_q[6:0], sd_miso};
        if (cnt_q == div_lat_q) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StFin;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = StLo;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StFin: begin
        // Placed after the W1C decode so a same-cycle clear loses.
        rx_d    = sh_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SD_SPI_CRC7_EN
  logic [6:0] crc_q, crc_d;
  logic       crc_fb;

  assign crc_fb = crc_q[6] ^ tx_bit;

  // CRC7 accumulates each transmitted bit once; a software clear wins.
  always_comb begin
    crc_d = crc_q;
    if (sample) crc_d = {crc_q[5:0], 1'b0} ^ ({7{crc_fb}} & 7'h09);
    if (bus.select && bus.we[0] && (bus.addr == 2'd2)) crc_d = '0;
  end

  // CRC register.
  always_ff @(posedge clk) begin
    if (reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end
`endif

  // Register read-back mux.
  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      2'd0: bus.rdata[7:0] = rx_q;
      2'd1: begin
        bus.rdata[0]          = cs_q;
        bus.rdata[1]          = busy;
        bus.rdata[2]          = done_q;
        bus.rdata[8 +: DIV_W] = div_q;
      end
`ifdef SD_SPI_CRC7_EN
      2'd2: bus.rdata[7:0] = {crc_q, 1'b1};
`endif
      default: bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboard bench for sd_spi_master: the stimulus pushes each transfer's
// expected MOSI byte / SCLK shape into a queue and a monitor pops it on every
// xfer_done rising edge. A card model shifts a random byte out on MISO.
module tb_sd_spi_master;

  logic clk = 1'b0;
  logic reset;
  logic xfer_done, sd_sclk, sd_mosi, sd_miso, sd_cs_n;

  always #5 clk = ~clk;

  sd_spi_master_if bus ();

  sd_spi_master dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .xfer_done (xfer_done),
    .sd_sclk   (sd_sclk),
    .sd_mosi   (sd_mosi),
    .sd_miso   (sd_miso),
    .sd_cs_n   (sd_cs_n)
  );

  typedef struct {
    logic [7:0] mosi;
    int         rises;
    int         hi;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Card model: presents card_byte MSB first, advancing on each SCLK fall.
  logic [7:0] card_byte;
  logic [7:0] mosi_cap;
  int         fall_cnt = 0;
  int         rise_cnt = 0;
  int         hi_cycles = 0;

  assign sd_miso = (fall_cnt < 8) ? card_byte[7 - fall_cnt] : 1'b1;

  always @(negedge sd_sclk) fall_cnt++;

  always @(posedge sd_sclk) begin
    mosi_cap = {mosi_cap[6:0], sd_mosi};
    rise_cnt++;
  end

  always @(negedge clk) if (sd_sclk === 1'b1) hi_cycles++;

  // Monitor: every completed transfer must match the oldest expectation.
  logic prev_done = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (xfer_done === 1'b1 && !prev_done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("mosi_byte", {24'h0, mosi_cap}, {24'h0, e.mosi});
        check("sclk_rises", rise_cnt, e.rises);
        check("sclk_hi_cycles", hi_cycles, e.hi);
      end
    end
    prev_done = (xfer_done === 1'b1);
  end

  task automatic wr(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
    bus.select = 1'b1;
    bus.addr   = a;
    bus.we     = w;
    bus.wdata  = d;
    @(negedge clk);
    bus.select = 1'b0;
    bus.we     = 4'h0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.select = 1'b1;
    bus.addr   = a;
    bus.we     = 4'h0;
    #1;
    d = bus.rdata;
    bus.select = 1'b0;
  endtask

  // inj: 0 none, 1 DATA write of FF mid-transfer, 2 div change mid-transfer,
  // 3 done W1C during the final busy cycle.
  task automatic transfer(input logic [7:0] tx, input logic [7:0] card, input int div,
                          input int inj, input int new_div);
    exp_t        e;
    int          busy_cnt;
    int          inj_at;
    logic [31:0] r;
    card_byte = card;
    fall_cnt  = 0;
    rise_cnt  = 0;
    hi_cycles = 0;
    mosi_cap  = 8'h00;
    e.mosi    = tx;
    e.rises   = 8;
    e.hi      = 8 * (div + 1);
    sbq.push_back(e);
    inj_at    = (inj == 3) ? 16 * (div + 1) : 2;
    wr(2'd0, 4'b0001, {24'h0, tx});
    busy_cnt = 0;
    r        = '0;
    for (int i = 0; i < 5000; i++) begin
      if (inj != 0 && busy_cnt == inj_at) begin
        if (inj == 1) wr(2'd0, 4'b0001, 32'h0000_00FF);
        else if (inj == 2) wr(2'd1, 4'b0011, (new_div << 8) | 32'h1);
        else wr(2'd1, 4'b0001, 32'h0000_0005);
        busy_cnt++;
        continue;
      end
      rd(2'd1, r);
      if (i == 0) check("done_cleared_on_start", {31'h0, r[2]}, 32'd0);
      if (!r[1]) break;
      busy_cnt++;
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, 16 * (div + 1) + 1);
    check("ctrl_done", {31'h0, r[2]}, 32'd1);
    check("xfer_done", {31'h0, xfer_done}, 32'd1);
    rd(2'd0, r);
    check("rx_byte", r, {24'h0, card});
    @(negedge clk);
  endtask

  function automatic logic [6:0] crc7_model(input logic [7:0] b[5]);
    logic [6:0] c = 7'h00;
    logic       fb;
    for (int i = 0; i < 40; i++) begin
      fb = c[6] ^ b[i / 8][7 - (i % 8)];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic send_cmd(input logic [7:0] b[5], input logic [7:0] exp_crc, input string name);
    logic [31:0] r;
    wr(2'd2, 4'b0001, 32'h0);
    for (int i = 0; i < 5; i++) transfer(b[i], 8'($urandom_range(0, 255)), 0, 0, 0);
    rd(2'd2, r);
    check(name, r, {24'h0, exp_crc});
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          div;
    int          nd;
    int          inj;
    logic [7:0]  cmd[5];
    bus.select = 1'b0;
    bus.addr   = 2'd0;
    bus.we     = 4'h0;
    bus.wdata  = 32'h0;
    card_byte  = 8'hFF;
    mosi_cap   = 8'h00;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_cs_n", {31'h0, sd_cs_n}, 32'd1);
    check("rst_sclk", {31'h0, sd_sclk}, 32'd0);
    check("rst_mosi", {31'h0, sd_mosi}, 32'd1);
    check("rst_xfer_done", {31'h0, xfer_done}, 32'd0);
    rd(2'd1, r);
    check("rst_ctrl", r, 32'h0000_3E00);
    rd(2'd0, r);
    check("rst_data", r, 32'h0);
    rd(2'd3, r);
    check("addr3", r, 32'h0);
    rd(2'd2, r);
`ifdef SD_SPI_CRC7_EN
    check("rst_crc", r, 32'h1);
`else
    check("addr2_no_crc", r, 32'h0);
`endif
    @(negedge clk);

    // div=0, cs=1, A5 out / 3C in, with an ignored FF write mid-transfer.
    wr(2'd1, 4'b0011, 32'h0000_0001);
    check("cs_n_asserted", {31'h0, sd_cs_n}, 32'd0);
    transfer(8'hA5, 8'h3C, 0, 1, 0);
    wr(2'd1, 4'b0001, 32'h0000_0005);
    check("w1c_xfer_done", {31'h0, xfer_done}, 32'd0);
    rd(2'd1, r);
    check("ctrl_after_w1c", r, 32'h0000_0001);
    @(negedge clk);

    // div=3, all-zero byte.
    wr(2'd1, 4'b0011, 32'h0000_0301);
    transfer(8'h00, 8'($urandom_range(0, 255)), 3, 0, 0);

    // Randomised transfers, including latched-div and done set-vs-clear races.
    div = 3;
    for (int k = 0; k < 12; k++) begin
      inj = $urandom_range(0, 3);
      nd  = $urandom_range(0, 4);
      transfer(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), div, inj, nd);
      if (inj == 2) begin
        rd(2'd1, r);
        check("div_latched_new", r & 32'hFF00, 32'(nd << 8));
        @(negedge clk);
        div = nd;
      end
      if ($urandom_range(0, 1) == 1) begin
        div = $urandom_range(0, 4);
        wr(2'd1, 4'b0011, (div << 8) | 32'h1);
      end
    end

`ifdef SD_SPI_CRC7_EN
    wr(2'd1, 4'b0011, 32'h0000_0001);
    cmd = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    send_cmd(cmd, 8'h95, "crc_cmd0");
    cmd = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};
    send_cmd(cmd, 8'h87, "crc_cmd8");
    for (int i = 0; i < 5; i++) cmd[i] = 8'($urandom_range(0, 255));
    send_cmd(cmd, {crc7_model(cmd), 1'b1}, "crc_random");
`else
    cmd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

    // Reset after the third SCLK rising edge aborts the transfer.
    wr(2'd1, 4'b0011, 32'h0000_0101);
    card_byte = 8'h5A;
    fall_cnt  = 0;
    rise_cnt  = 0;
    wr(2'd0, 4'b0001, 32'h0000_00C3);
    for (int i = 0; i < 2000; i++) begin
      if (rise_cnt >= 3) break;
      @(negedge clk);
    end
    check("third_rise_seen", {31'h0, rise_cnt >= 3}, 32'd1);
    check("cs_n_mid_xfer", {31'h0, sd_cs_n}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd(2'd1, r);
    check("abort_ctrl", r, 32'h0000_3E00);
    rd(2'd0, r);
    check("abort_data", r, 32'h0);
    check("abort_sclk", {31'h0, sd_sclk}, 32'd0);
    check("abort_mosi", {31'h0, sd_mosi}, 32'd1);
    check("abort_cs_n", {31'h0, sd_cs_n}, 32'd1);
    check("abort_xfer_done", {31'h0, xfer_done}, 32'd0);
    @(negedge clk);

    // Recovery transfer at the reset divider.
    wr(2'd1, 4'b0001, 32'h0000_0001);
    transfer(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 62, 0, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
